// File: rtl/fp_exe_sched_pkg.sv
// Shared FPU execution-port types plus scheduler state for fp_exe_sched.
package fp_wire;

    typedef struct packed {
        logic [31:0] data1;
        logic [31:0] data2;
        logic [31:0] data3;
        logic [4:0]  op;
        logic [1:0]  fmt;
        logic [2:0]  rm;
        logic        enable;
    } fp_exe_in_type;

    typedef struct packed {
        logic [31:0] result;
        logic [4:0]  flags;
        logic        ready;
    } fp_exe_out_type;

    typedef enum logic {IDLE, WAIT} fp_sched_state_type;

    // owner/rr_last/rsp_valid are sized for the maximum of 8 channels.
    typedef struct packed {
        fp_sched_state_type state;
        logic [2:0]         owner;
        logic [2:0]         rr_last;
        logic               kill;
        fp_exe_in_type      fpu_o;
        fp_exe_out_type     rsp_data;
        logic [7:0]         rsp_valid;
    } fp_sched_reg_type;

    localparam fp_sched_reg_type init_fp_sched_reg = '{
        state:     IDLE,
        owner:     3'd0,
        rr_last:   3'd0,
        kill:      1'b0,
        fpu_o:     '0,
        rsp_data:  '0,
        rsp_valid: 8'd0
    };

endpackage

// File: rtl/fp_exe_sched_fifo.sv
// Per-channel request FIFO; pointers carry one extra wrap bit to tell full from empty.
module fp_sched_fifo
    import fp_wire::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_i,
    input  logic          pop_i,
    input  logic          clear_i,
    input  fp_exe_in_type data_i,
    output fp_exe_in_type data_o,
    output logic          full_o,
    output logic          empty_o
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW:0] PtrOne = {{AW{1'b0}}, 1'b1};

    logic [AW:0]   wptr_q, wptr_d, rptr_q, rptr_d;
    fp_exe_in_type mem_q [DEPTH];
    logic          do_push;

    assign do_push = push_i && !full_o && !clear_i;
    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) && (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign data_o  = mem_q[rptr_q[AW-1:0]];

    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (clear_i) begin
            wptr_d = '0;
            rptr_d = '0;
        end else begin
            if (do_push) wptr_d = wptr_q + PtrOne;
            if (pop_i && !empty_o) rptr_d = rptr_q + PtrOne;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem_q[wptr_q[AW-1:0]] <= data_i;
    end

endmodule

// File: rtl/fp_exe_sched.sv
// Round-robin scheduler sharing one fp_unit port among NCH requesters.
// Optional FP_SCHED_BYPASS_EN lets an idle, empty channel skip its FIFO.
module fp_exe_sched
    import fp_wire::*;
#(
    parameter int unsigned NCH   = 2,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [NCH-1:0]           req_valid,
    output logic [NCH-1:0]           req_ready,
    input  fp_exe_in_type [NCH-1:0]  req_data,
    input  logic [NCH-1:0]           clear,
    output logic [NCH-1:0]           rsp_valid,
    output fp_exe_out_type           rsp_data,
    output fp_exe_in_type            fpu_o,
    input  fp_exe_out_type           fpu_i,
    output logic                     busy
);

    fp_sched_reg_type        r_q, r_d;
    logic [NCH-1:0]          full, empty, push, pop, byp_ok, byp_take;
    fp_exe_in_type [NCH-1:0] head;
    logic [7:0]              elig, clear8;
    logic                    found, grant_byp;
    logic [2:0]              gch, cand;
    fp_exe_in_type           gdata;

    assign req_ready = ~full & ~clear & {NCH{~reset}};
    assign push      = req_valid & req_ready & ~byp_take;

    for (genvar c = 0; c < NCH; c++) begin : g_ch
        fp_sched_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clock   (clock),
            .reset   (reset),
            .push_i  (push[c]),
            .pop_i   (pop[c]),
            .clear_i (clear[c]),
            .data_i  (req_data[c]),
            .data_o  (head[c]),
            .full_o  (full[c]),
            .empty_o (empty[c])
        );
    end

    always_comb begin
        elig   = '0;
        clear8 = '0;
        byp_ok = '0;
        for (int c = 0; c < int'(NCH); c++) begin
            clear8[c] = clear[c];
            elig[c]   = !empty[c] && !clear[c];
`ifdef FP_SCHED_BYPASS_EN
            // Only an empty FIFO may bypass so per-channel order is kept.
            byp_ok[c] = empty[c] && req_valid[c] && req_ready[c];
            elig[c]   = elig[c] || byp_ok[c];
`endif
        end
    end

    always_comb begin
        found = 1'b0;
        gch   = '0;
        cand  = '0;
        for (int i = 1; i <= int'(NCH); i++) begin
            cand = 3'((int'(r_q.rr_last) + i) % int'(NCH));
            if (!found && elig[cand]) begin
                found = 1'b1;
                gch   = cand;
            end
        end
    end

    always_comb begin
        gdata     = '0;
        grant_byp = 1'b0;
        for (int c = 0; c < int'(NCH); c++) begin
            if (gch == 3'(c)) begin
                grant_byp = byp_ok[c];
                gdata     = byp_ok[c] ? req_data[c] : head[c];
            end
        end
    end

    always_comb begin
        r_d           = r_q;
        r_d.rsp_valid = '0;
        pop           = '0;
        byp_take      = '0;
        case (r_q.state)
            IDLE: begin
                if (found) begin
                    r_d.fpu_o        = gdata;
                    r_d.fpu_o.enable = 1'b1;
                    r_d.owner        = gch;
                    r_d.rr_last      = gch;
                    r_d.kill         = 1'b0;
                    r_d.state        = WAIT;
                    for (int c = 0; c < int'(NCH); c++) begin
                        if (gch == 3'(c)) begin
                            pop[c]      = !grant_byp;
                            byp_take[c] = grant_byp;
                        end
                    end
                end
            end
            WAIT: begin
                r_d.fpu_o.enable = 1'b0;
                r_d.kill         = r_q.kill | clear8[r_q.owner];
                // Ready during the issue cycle belongs to no op of ours.
                if (fpu_i.ready && !r_q.fpu_o.enable) begin
                    r_d.rsp_data.result      = fpu_i.result;
                    r_d.rsp_data.flags       = fpu_i.flags;
                    r_d.rsp_valid[r_q.owner] = !r_d.kill;
                    r_d.state                = IDLE;
                end
            end
            default: r_d.state = IDLE;
        endcase
        r_d.rsp_data.ready = |r_d.rsp_valid;
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_q         <= init_fp_sched_reg;
            r_q.rr_last <= 3'(NCH - 1);
        end else begin
            r_q <= r_d;
        end
    end

    assign fpu_o     = r_q.fpu_o;
    assign rsp_data  = r_q.rsp_data;
    assign rsp_valid = r_q.rsp_valid[NCH-1:0];
    assign busy      = (r_q.state != IDLE) || (|(~empty));

endmodule

// File: tb/tb_fp_exe_sched.sv
// Self-checking bench for fp_exe_sched: transaction-level queue model plus stub fp_unit.
`timescale 1ns/1ps
module tb_fp_exe_sched;
    import fp_wire::*;

    localparam int unsigned NCH   = 2;
    localparam int unsigned DEPTH = 4;

    logic                    clock = 1'b0;
    logic                    reset;
    logic [NCH-1:0]          req_valid, req_ready, clear, rsp_valid;
    fp_exe_in_type [NCH-1:0] req_data;
    fp_exe_out_type          rsp_data;
    fp_exe_out_type          fpu_i = '0;
    fp_exe_in_type           fpu_o;
    logic                    busy;

    always #5 clock = ~clock;

    fp_exe_sched #(.NCH(NCH), .DEPTH(DEPTH)) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_data  (req_data),
        .clear     (clear),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .fpu_o     (fpu_o),
        .fpu_i     (fpu_i),
        .busy      (busy)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    bit armed = 0;

    // Model: queued payloads per channel and the expected registered outputs.
    fp_exe_in_type  mq [NCH][$];
    bit             m_wait;
    int             m_owner, m_rr, m_age;
    bit             m_kill;
    fp_exe_in_type  m_fpu;
    fp_exe_out_type m_rsp;
    logic [NCH-1:0] m_rsp_valid;

    // Observations of the DUT for the hand-computed checks.
    logic [31:0] issue_log[$];
    logic [31:0] rlog [NCH][$];
    int          en_cyc, rsp_cyc;

    // Stub fp_unit: returns data3 as result, op as flags, 3 cycles after enable.
    bit            stall = 0, inject = 0, st_pend = 0;
    int            st_cnt;
    fp_exe_in_type st_op;

    task automatic chk(string name, logic [127:0] act, logic [127:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%h want=%h", name, cyc, act, exp);
        end
    endtask

    always @(posedge clock) begin
        logic [NCH-1:0] rdy_pre, exp_rdy;
        int  g;
        bit  gbyp, any;
        #1;
        cyc++;
        for (int c = 0; c < NCH; c++)
            rdy_pre[c] = (mq[c].size() < DEPTH) && !clear[c] && !reset;
        if (reset) begin
            armed = 1;
            for (int c = 0; c < NCH; c++) mq[c].delete();
            m_wait = 0; m_rr = NCH - 1; m_kill = 0; m_owner = 0; m_age = 0;
            m_fpu = '0; m_rsp = '0; m_rsp_valid = '0;
        end else begin
            m_rsp_valid = '0;
            m_rsp.ready = 1'b0;
            g = -1;
            gbyp = 0;
            if (!m_wait) begin
                for (int i = 1; i <= NCH; i++) begin
                    int c;
                    c = (m_rr + i) % NCH;
                    if (g < 0) begin
                        if (mq[c].size() > 0 && !clear[c]) g = c;
`ifdef FP_SCHED_BYPASS_EN
                        else if (mq[c].size() == 0 && req_valid[c] && rdy_pre[c]) begin
                            g = c;
                            gbyp = 1;
                        end
`endif
                    end
                end
                if (g >= 0) begin
                    if (gbyp) m_fpu = req_data[g];
                    else m_fpu = mq[g].pop_front();
                    m_fpu.enable = 1'b1;
                    m_owner = g; m_rr = g; m_kill = 0; m_wait = 1; m_age = 0;
                end
            end else begin
                m_fpu.enable = 1'b0;
                if (clear[m_owner]) m_kill = 1;
                if (fpu_i.ready && m_age > 0) begin
                    m_rsp.result = fpu_i.result;
                    m_rsp.flags  = fpu_i.flags;
                    if (!m_kill) begin
                        m_rsp_valid[m_owner] = 1'b1;
                        m_rsp.ready = 1'b1;
                    end
                    m_wait = 0;
                end
                m_age++;
            end
            for (int c = 0; c < NCH; c++) begin
                if (clear[c]) mq[c].delete();
                if (req_valid[c] && rdy_pre[c] && !(gbyp && g == c)) mq[c].push_back(req_data[c]);
            end
        end

        if (armed) begin
            any = m_wait;
            for (int c = 0; c < NCH; c++) begin
                exp_rdy[c] = (mq[c].size() < DEPTH) && !clear[c] && !reset;
                if (mq[c].size() > 0) any = 1;
            end
            chk("fpu_o", 128'(fpu_o), 128'(m_fpu));
            chk("rsp_valid", 128'(rsp_valid), 128'(m_rsp_valid));
            chk("rsp_data", 128'(rsp_data), 128'(m_rsp));
            chk("req_ready", 128'(req_ready), 128'(exp_rdy));
            chk("busy", 128'(busy), 128'(any));
        end

        if (fpu_o.enable) begin
            en_cyc = cyc;
            issue_log.push_back(fpu_o.data1);
        end
        for (int c = 0; c < NCH; c++) begin
            if (rsp_valid[c]) begin
                rsp_cyc = cyc;
                rlog[c].push_back(rsp_data.result);
            end
        end

        if (reset) begin
            st_pend = 0;
            fpu_i = '0;
        end else begin
            fpu_i.ready = 1'b0;
            if (inject) begin
                fpu_i.ready = 1'b1;
                inject = 0;
            end else if (st_pend) begin
                if (st_cnt > 0) st_cnt--;
                if (st_cnt == 0 && !stall) begin
                    fpu_i.result = st_op.data3;
                    fpu_i.flags  = st_op.op;
                    fpu_i.ready  = 1'b1;
                    st_pend = 0;
                end
            end
            if (fpu_o.enable) begin
                st_pend = 1;
                st_cnt = 3;
                st_op = fpu_o;
            end
        end
    end

    function automatic fp_exe_in_type mk(logic [31:0] d1, logic [31:0] d3);
        fp_exe_in_type p;
        p = '0;
        p.data1 = d1;
        p.data2 = 32'h4000_0000;
        p.data3 = d3;
        p.op    = 5'(d1[4:0] | 5'd1);
        return p;
    endfunction

    task automatic cycles(int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic push2(logic [NCH-1:0] v, fp_exe_in_type d0, fp_exe_in_type d1);
        req_valid = v;
        req_data[0] = d0;
        req_data[1] = d1;
        @(negedge clock);
        req_valid = '0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        req_valid = '0;
        clear = '0;
        cycles(2);
        reset = 1'b0;
        issue_log.delete();
        for (int c = 0; c < NCH; c++) rlog[c].delete();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog cycle=%0d got=timeout want=finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        reset = 1'b1; req_valid = '0; clear = '0; req_data = '0;
        @(negedge clock);
        do_reset();

        // Single op: 1.0 + 2.0 on ch0, stub returns 3.0.
        t = cyc;
        push2(2'b01, mk(32'h3f80_0000, 32'h4040_0000), '0);
        cycles(8);
`ifdef FP_SCHED_BYPASS_EN
        chk("single_en_cycle", 128'(en_cyc), 128'(t + 1));
        chk("single_rsp_cycle", 128'(rsp_cyc), 128'(t + 5));
`else
        chk("single_en_cycle", 128'(en_cyc), 128'(t + 2));
        chk("single_rsp_cycle", 128'(rsp_cyc), 128'(t + 6));
`endif
        chk("single_rsp_n0", 128'(rlog[0].size()), 128'(1));
        if (rlog[0].size() == 1) chk("single_result", 128'(rlog[0][0]), 128'(32'h4040_0000));
        chk("single_rsp_n1", 128'(rlog[1].size()), 128'(0));

        // Round-robin with both channels loaded.
        do_reset();
        push2(2'b11, mk(32'h00, 32'h00), mk(32'h10, 32'h10));
        push2(2'b11, mk(32'h01, 32'h01), mk(32'h11, 32'h11));
        cycles(30);
        chk("rr_issue_n", 128'(issue_log.size()), 128'(4));
        if (issue_log.size() == 4)
            chk("rr_order", {issue_log[0], issue_log[1], issue_log[2], issue_log[3]},
                {32'h00, 32'h10, 32'h01, 32'h11});
        chk("rr_ch0", {rlog[0].size() == 2 ? rlog[0][1] : 32'hdead, rlog[0].size() == 2 ? rlog[0][0] : 32'hdead},
            {32'h01, 32'h00});
        chk("rr_ch1", {rlog[1].size() == 2 ? rlog[1][1] : 32'hdead, rlog[1].size() == 2 ? rlog[1][0] : 32'hdead},
            {32'h11, 32'h10});

        // Full and wrap on ch1 while ch0 holds the stalled FPU.
        do_reset();
        stall = 1;
        push2(2'b01, mk(32'ha0, 32'ha0), '0);
        cycles(3);
        for (int i = 0; i < 4; i++) push2(2'b10, '0, mk(32'h10 + i, 32'h10 + i));
        chk("full_ready", 128'(req_ready[1]), 128'(0));
        push2(2'b10, '0, mk(32'h14, 32'h14));
        stall = 0;
        cycles(40);
        for (int i = 0; i < 4; i++) push2(2'b10, '0, mk(32'h20 + i, 32'h20 + i));
        cycles(40);
        chk("wrap_n", 128'(rlog[1].size()), 128'(8));
        if (rlog[1].size() == 8)
            chk("wrap_order", {rlog[1][0], rlog[1][1], rlog[1][2], rlog[1][3]},
                {32'h10, 32'h11, 32'h12, 32'h13});
        if (rlog[1].size() == 8)
            chk("wrap_order2", {rlog[1][4], rlog[1][5], rlog[1][6], rlog[1][7]},
                {32'h20, 32'h21, 32'h22, 32'h23});

        // Clear while ch0's op is in flight.
        do_reset();
        stall = 1;
        for (int i = 0; i < 3; i++) push2(2'b01, mk(32'hb0 + i, 32'hb0 + i), '0);
        cycles(3);
        clear = 2'b01;
        @(negedge clock);
        clear = '0;
        stall = 0;
        cycles(8);
        chk("clear_no_rsp", 128'(rlog[0].size()), 128'(0));
        chk("clear_busy", 128'(busy), 128'(0));
        chk("clear_issued", 128'(issue_log.size()), 128'(1));

        // Reset in WAIT, then a stray ready.
        do_reset();
        stall = 1;
        push2(2'b10, '0, mk(32'hc0, 32'hc0));
        cycles(3);
        reset = 1'b1;
        @(negedge clock);
        chk("rst_fpu_o", 128'(fpu_o), 128'(0));
        chk("rst_outs", {rsp_valid, req_ready, busy}, '0);
        reset = 1'b0;
        stall = 0;
        @(negedge clock);
        inject = 1;
        cycles(4);
        chk("rst_no_rsp", 128'(rlog[1].size()), 128'(0));

        // Bypass latency and per-channel order with a non-empty FIFO.
        do_reset();
        t = cyc;
        push2(2'b01, mk(32'hd0, 32'hd0), '0);
        cycles(6);
`ifdef FP_SCHED_BYPASS_EN
        chk("byp_en_cycle", 128'(en_cyc), 128'(t + 1));
`else
        chk("byp_en_cycle", 128'(en_cyc), 128'(t + 2));
`endif
        stall = 1;
        push2(2'b01, mk(32'he0, 32'he0), '0);
        push2(2'b10, '0, mk(32'hf0, 32'hf0));
        push2(2'b10, '0, mk(32'hf1, 32'hf1));
        cycles(2);
        stall = 0;
        push2(2'b10, '0, mk(32'hf2, 32'hf2));
        cycles(30);
        chk("order_n", 128'(rlog[1].size()), 128'(3));
        if (rlog[1].size() == 3)
            chk("order_ch1", {rlog[1][0], rlog[1][1], rlog[1][2]}, {32'hf0, 32'hf1, 32'hf2});

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fp_exe_sched.md
# fp_exe_sched

Parametrised multi-channel request scheduler that sits in front of the single-issue `fp_unit` execution port. It lets NCH independent requesters (integer pipes, vector lanes, a debug port) share one FPU. Each channel has its own request FIFO. A round-robin arbiter issues one operation at a time on `fp_exe_in_type`, waits for the unit's variable-latency `ready`, and routes result and flags back to the originating channel.

## Interface
Parameters:
- NCH, 2, number of requester channels (1..8)
- DEPTH, 4, entries per channel FIFO (power of two, ≥2)

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- req_valid  in  NCH  per-channel request strobe
- req_ready  out  NCH  per-channel accept; transfer occurs when valid&ready
- req_data  in  NCH×fp_exe_in_type  operation payload; `enable` field ignored
- clear  in  NCH  per-channel flush
- rsp_valid  out  NCH  one-cycle result strobe; no backpressure
- rsp_data  out  fp_exe_out_type  result/flags of the strobed channel; `ready` mirrors OR of rsp_valid
- fpu_o  out  fp_exe_in_type  to fp_unit
- fpu_i  in  fp_exe_out_type  from fp_unit
- busy  out  1  FSM not IDLE or any FIFO non-empty

## Operation
- Clock and reset: one clock, `clock`; reset is synchronous and active-high on `reset`.
- Reset values:
  - all FIFOs empty; FSM IDLE
  - rr_last = NCH-1, so channel 0 has first priority
  - fpu_o = 0; rsp_valid = 0; rsp_data = 0; busy = 0
  - req_ready = 0 while reset is high
- req_ready[c] = !full[c] & !clear[c] & !reset.
- FIFO: DEPTH entries, read/write pointers clog2(DEPTH)+1 bits; the MSB distinguishes full from empty on wrap.
- FSM states:
  - IDLE: eligible channels are FIFO non-empty and clear low. Grant the first eligible channel searching from rr_last+1 modulo NCH. On grant: pop the head entry, register it onto fpu_o with enable=1, set owner=c, rr_last=c, kill=0, go WAIT. No eligible channel: stay IDLE.
  - WAIT: fpu_o.enable=0; payload fields hold. When fpu_i.ready=1, register result/flags into rsp_data. Pulse rsp_valid[owner] unless kill=1. Go IDLE.
- fpu_i.ready is ignored in IDLE and in the cycle enable is high.
- clear[c] empties FIFO c at the edge. A same-cycle push on c is refused (req_ready low). If owner==c in WAIT, set kill=1: the op completes, but its response is dropped and the FSM still returns to IDLE.
- Reset mid-operation: the FSM returns to IDLE and the in-flight op is abandoned; the fp_unit shares the reset.
- Simultaneous push and pop on one FIFO: both occur; occupancy is unchanged.

## Timing
- Push accepted in cycle t → fpu_o.enable high in cycle t+2 (FIFO path) if the FSM is IDLE and the channel wins arbitration.
- fpu_i.ready in cycle r → rsp_valid high in cycle r+1 for exactly one cycle. FSM is IDLE in r+1; next enable is no earlier than r+2.
- Throughput: one op per (FPU latency + 2) cycles.
- enable is never high for two consecutive cycles.

## Configuration
- Macro: `FP_SCHED_BYPASS_EN`.
- Defined:
  - In IDLE, a channel with an empty FIFO and req_valid&req_ready is also eligible.
  - If granted, the payload goes directly to fpu_o, enable is high in cycle t+1, and the entry is not written to the FIFO.
  - Arbitration order is unchanged. A channel with a non-empty FIFO never bypasses, which preserves per-channel order.
- Undefined: all requests go through the FIFO; latency is t+2.

## Structure
- Add to package fp_wire:
  - `fp_sched_state_type` enum {IDLE, WAIT}
  - `fp_sched_reg_type` (state, owner, rr_last, kill, fpu_o, rsp_data, rsp_valid)
  - constant `init_fp_sched_reg`
- One sub-module `fp_sched_fifo` (parameter DEPTH; payload fp_exe_in_type; push, pop, clear, full, empty), instantiated NCH times in a generate loop.

## Test plan
- Single op, NCH=2: channel 0 pushes fadd at t; stub FPU returns ready 3 cycles after enable, result 32'h40400000 → enable at t+2, rsp_valid[0] at t+6, rsp_data.result=32'h40400000, rsp_valid[1]=0.
- Round-robin: both channels push 2 ops at t with the FIFOs pre-filled → issue order ch0, ch1, ch0, ch1; each response goes to the matching channel.
- Full/wrap, DEPTH=4: push 5 ops on ch1 while the FPU stalls ready → req_ready[1]=0 after the 4th. Drain 4, push 4 more → all 8 results in order, pointers wrap correctly.
- Clear in flight: ch0 op in WAIT, ch0 holds 2 queued ops; assert clear[0] → FIFO empty next cycle, the ready of the in-flight op yields no rsp_valid[0], FSM returns IDLE, busy=0.
- Reset mid-WAIT: assert reset during WAIT → next cycle all outputs 0, req_ready=0. After deassert, a late fpu_i.ready produces no response.
- FP_SCHED_BYPASS_EN defined: push on idle, empty ch0 at t → enable at t+1. Push on ch1 while its FIFO is non-empty → FIFO path, order preserved.
